alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Operand-fetch and issue stage that sits directly upstream of the 32-bit ALU. It accepts decoded ALU instructions, reads two operands from an internal 32×32 register file, selects register or immediate for B, and presents registered `A`/`B`/`mode` to the ALU through a valid/ready handshake. It also accepts write-backs and tracks pending destinations in a scoreboard, so an instruction never issues with a stale operand.

## Interface
Parameters:
- `XLEN`, 32, data width; must match the ALU.
- `NREG`, 32, number of registers; address width `$clog2(NREG)` = 5.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: instruction accepted this cycle when `in_valid && in_ready`.
- `in_rs1` in 5: source register for A.
- `in_rs2` in 5: source register for B; ignored when `in_use_imm`.
- `in_imm` in 32: immediate, already sign-extended by decode.
- `in_use_imm` in 1: B comes from `in_imm`, not `in_rs2`.
- `in_mode` in 3: ALU op. 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra.
- `in_rd` in 5: destination register; 0 means no write.
- `wb_en` in 1: write-back strobe.
- `wb_rd` in 5: write-back register.
- `wb_data` in 32: write-back value.
- `out_valid` out 1: ALU operands valid.
- `out_ready` in 1: downstream consumes when `out_valid && out_ready`.
- `out_a` out 32: ALU operand A.
- `out_b` out 32: ALU operand B.
- `out_mode` out 3: ALU mode.
- `out_rd` out 5: destination, carried to write-back.

## Operation
- Register file: x0 reads 0 and ignores writes. Writes happen on the rising edge when `wb_en && wb_rd != 0`.
- Read bypass: if `wb_en && wb_rd == rs && rs != 0` in the same cycle, the operand is `wb_data`, not the array value.
- Scoreboard: `pending[NREG-1:0]`.
  - On accept with `in_rd != 0`, set `pending[in_rd]`.
  - On `wb_en`, clear `pending[wb_rd]`.
  - If both hit the same register in one cycle, set wins. `pending[0]` is always 0.
- A source register is "ready" when it is not pending, or when it is being written back this cycle (bypassed).
- `hazard` is asserted when any of these hold:
  - rs1 is not ready;
  - `!in_use_imm` and rs2 is not ready;
  - `in_rd != 0` and `pending[in_rd]` is set (WAW stall).
- `in_ready = (!out_valid || out_ready) && !hazard`. It is combinational and does not depend on `in_valid`.
- B selection:
  - `in_use_imm` → `in_imm`, otherwise the rs2 value.
  - For modes 5–7, B is masked to `{27'b0, B[4:0]}`, because the ALU shifts by full B.
- Output register:
  - Loads `{a, b, mode, rd}` and sets `out_valid` on accept.
  - Clears `out_valid` on consume without a new accept.
  - Holds all fields stable while `out_valid && !out_ready`.
- Simultaneous consume and accept: the output register is reloaded and `out_valid` stays 1. There are no bubbles.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Throughput is 1 instruction per cycle when there is no hazard and `out_ready` is held high.
- A write-back at edge N is visible in the same cycle through the bypass, and from the array after edge N.
- Dependent back-to-back instructions stall until their producer's write-back cycle. During that cycle the dependent issues with bypassed data.
- Reset (asynchronous, any time):
  - register file = 0, `pending` = 0, `out_valid` = 0;
  - `out_a`/`out_b` = 0, `out_mode` = 0, `out_rd` = 0;
  - in-flight instructions are discarded;
  - `in_ready` follows the combinational rule on the cleared state.

## Structure
- Shared package `alu_pkg`:
  - `XLEN`;
  - mode constants `ALU_ADD`…`ALU_SRA` (0–7);
  - `alu_mode_t` (3-bit);
  - `reg_addr_t` (5-bit).
- The ALU and this stage both import `alu_pkg`.
- Sub-module `reg_file_2r1w`: two combinational reads with write bypass, one synchronous write, x0 = 0, asynchronous reset to 0.
- The scoreboard, hazard logic and output register stay in `alu_issue_stage`.

## Test plan
- After reset, write x1=5 and x2=3. Issue add rs1=1 rs2=2 rd=3 → next cycle `out_a`=5, `out_b`=3, `out_mode`=0, `out_rd`=3, `out_valid`=1.
- Issue rd=3, then rs1=3 with no write-back → `in_ready`=0. Assert `wb_en` with `wb_rd`=3, `wb_data`=0x1234 → accepted that cycle, next cycle `out_a`=0x1234.
- `in_use_imm`=1, `in_imm`=0xFFFF_FFE5, mode=7 → `out_b`=0x0000_0005. With mode=0 → `out_b`=0xFFFF_FFE5.
- Set `wb_rd`=0 with `wb_data`=0xDEAD, then issue rs1=0 → `out_a`=0. An instruction with rd=0 never sets pending and never stalls.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → outputs stable and `in_ready`=0. Release → one transfer per cycle, no instruction lost or duplicated.
- Assert `rst` mid-stream with `out_valid`=1 and pending bits set → all outputs 0 at once. After release, an instruction reading a previously pending register issues without stall.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, register-file size, op encodings and small helpers.
// Imported by the ALU and by the issue stage that feeds it.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [2:0] alu_mode_t;
  typedef logic [4:0] reg_addr_t;

  localparam alu_mode_t ALU_ADD = 3'd0;
  localparam alu_mode_t ALU_SUB = 3'd1;
  localparam alu_mode_t ALU_AND = 3'd2;
  localparam alu_mode_t ALU_OR  = 3'd3;
  localparam alu_mode_t ALU_XOR = 3'd4;
  localparam alu_mode_t ALU_SLL = 3'd5;
  localparam alu_mode_t ALU_SRL = 3'd6;
  localparam alu_mode_t ALU_SRA = 3'd7;

  function automatic logic is_shift(input alu_mode_t mode);
    return mode >= ALU_SLL;
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Two combinational read ports with same-cycle write bypass and one synchronous write port.
// Register 0 is hardwired to zero.
module reg_file_2r1w #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREG];

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (we && wa == ra1 && ra1 != '0) rd1 = wd;
    if (we && wa == ra2 && ra2 != '0) rd2 = wd;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch and issue stage in front of the ALU: register read, immediate select,
// scoreboard-based hazard stall and a one-entry output register with valid/ready handshake.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int NREG = alu_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  reg_addr_t       in_rs1,
  input  reg_addr_t       in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  alu_mode_t       in_mode,
  input  reg_addr_t       in_rd,
  input  logic            wb_en,
  input  reg_addr_t       wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output alu_mode_t       out_mode,
  output reg_addr_t       out_rd
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] b_sel;
  logic            rs1_ok;
  logic            rs2_ok;
  logic            hazard;
  logic            accept;

  reg_file_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (in_rs1),
    .ra2 (in_rs2),
    .rd1 (rs1_val),
    .rd2 (rs2_val),
    .we  (wb_en),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  // A pending source is still usable in the cycle its write-back arrives, via the bypass.
  always_comb begin
    rs1_ok   = !pending[in_rs1] || (wb_en && wb_rd == in_rs1);
    rs2_ok   = !pending[in_rs2] || (wb_en && wb_rd == in_rs2);
    hazard   = !rs1_ok || (!in_use_imm && !rs2_ok) || (in_rd != '0 && pending[in_rd]);
    in_ready = (!out_valid || out_ready) && !hazard;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (accept && in_rd != '0) set_mask[in_rd] = 1'b1;
    if (wb_en) clr_mask[wb_rd] = 1'b1;
  end

  // Set is applied after clear so a same-cycle issue and write-back leave the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & ~NREG'(1);
    end
  end

  // The ALU shifts by the whole B operand, so shift amounts are trimmed to 5 bits here.
  always_comb begin
    b_sel = in_use_imm ? in_imm : rs2_val;
    if (is_shift(in_mode)) b_sel = {{(XLEN-5){1'b0}}, b_sel[4:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_mode  <= ALU_ADD;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= rs1_val;
      out_b     <= b_sel;
      out_mode  <= in_mode;
      out_rd    <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by random traffic,
// all compared against a register/scoreboard reference model kept in the bench.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_mode;
  logic [4:0]  in_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_mode;
  logic [4:0]  out_rd;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [2:0]  m_mode;
  logic [4:0]  m_rd;
  logic        last_ready;

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_mode    (in_mode),
    .in_rd      (in_rd),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_mode   (out_mode),
    .out_rd     (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_a = 32'd0;
    m_b = 32'd0;
    m_mode = 3'd0;
    m_rd = 5'd0;
  endfunction

  // Value a source register holds this cycle, including a write-back landing now.
  function automatic logic [31:0] modelOperand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit modelSrcUsable(input logic [4:0] r);
    return !m_pend[r] || (wb_en && wb_rd == r);
  endfunction

  function automatic bit modelReady();
    bit stall;
    stall = !modelSrcUsable(in_rs1)
         || (!in_use_imm && !modelSrcUsable(in_rs2))
         || (in_rd != 5'd0 && m_pend[in_rd]);
    return (!m_valid || out_ready) && !stall;
  endfunction

  task automatic expectField(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic checkOutput(input string tag);
    expectField({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      expectField({tag, ".out_a"}, out_a, m_a);
      expectField({tag, ".out_b"}, out_b, m_b);
      expectField({tag, ".out_mode"}, {29'd0, out_mode}, {29'd0, m_mode});
      expectField({tag, ".out_rd"}, {27'd0, out_rd}, {27'd0, m_rd});
    end
  endtask

  task automatic checkReset(input string tag);
    expectField({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    expectField({tag, ".out_a"}, out_a, 32'd0);
    expectField({tag, ".out_b"}, out_b, 32'd0);
    expectField({tag, ".out_mode"}, {29'd0, out_mode}, 32'd0);
    expectField({tag, ".out_rd"}, {27'd0, out_rd}, 32'd0);
  endtask

  // One clock cycle: drive inputs, check in_ready, advance the model, check registered outputs.
  task automatic applyStimulus(
    input string tag,
    input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [31:0] imm, input bit ui, input logic [2:0] mode, input logic [4:0] rd,
    input bit we, input logic [4:0] wr, input logic [31:0] wd, input bit ordy);
    bit          exp_ready;
    logic [31:0] a;
    logic [31:0] b;
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_use_imm = ui;
    in_mode = mode; in_rd = rd; wb_en = we; wb_rd = wr; wb_data = wd; out_ready = ordy;
    #1;
    exp_ready  = modelReady();
    last_ready = in_ready;
    expectField({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
    a = modelOperand(rs1);
    b = ui ? imm : modelOperand(rs2);
    if (mode >= 3'd5) b = b % 32;
    if (v && exp_ready) begin
      m_valid = 1'b1; m_a = a; m_b = b; m_mode = mode; m_rd = rd;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    if (we) m_pend[wr] = 1'b0;
    if (v && exp_ready && rd != 5'd0) m_pend[rd] = 1'b1;
    if (we && wr != 5'd0) m_regs[wr] = wd;
    @(posedge clk);
    #1;
    checkOutput(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input bit we, input logic [4:0] wr, input logic [31:0] wd);
    applyStimulus(tag, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 3'd0, 5'd0, we, wr, wd, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_use_imm = 1'b0;
    in_mode = '0; in_rd = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    modelReset();
    #1;
    checkReset("reset");
    @(negedge clk);
    rst = 1'b0;

    idle("wb_x1", 1'b1, 5'd1, 32'd5);
    idle("wb_x2", 1'b1, 5'd2, 32'd3);
    applyStimulus("add", 1'b1, 5'd1, 5'd2, 32'd0, 1'b0, 3'd0, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1);
    expectField("add.a", out_a, 32'd5);
    expectField("add.b", out_b, 32'd3);
    expectField("add.rd", {27'd0, out_rd}, 32'd3);

    applyStimulus("raw_stall", 1'b1, 5'd3, 5'd0, 32'd0, 1'b0, 3'd1, 5'd4, 1'b0, 5'd0, 32'd0, 1'b1);
    expectField("raw_stall.ready", {31'd0, last_ready}, 32'd0);
    applyStimulus("raw_bypass", 1'b1, 5'd3, 5'd0, 32'd0, 1'b0, 3'd1, 5'd4, 1'b1, 5'd3, 32'h1234, 1'b1);
    expectField("raw_bypass.a", out_a, 32'h1234);

    applyStimulus("imm_sra", 1'b1, 5'd0, 5'd9, 32'hFFFF_FFE5, 1'b1, 3'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    expectField("imm_sra.b", out_b, 32'h0000_0005);
    applyStimulus("imm_add", 1'b1, 5'd0, 5'd9, 32'hFFFF_FFE5, 1'b1, 3'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    expectField("imm_add.b", out_b, 32'hFFFF_FFE5);

    idle("wb_x0", 1'b1, 5'd0, 32'hDEAD);
    applyStimulus("read_x0", 1'b1, 5'd0, 5'd0, 32'd0, 1'b0, 3'd2, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    expectField("read_x0.a", out_a, 32'd0);
    applyStimulus("rd0_again", 1'b1, 5'd0, 5'd0, 32'd0, 1'b0, 3'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    expectField("rd0_again.ready", {31'd0, last_ready}, 32'd1);

    applyStimulus("bp_load", 1'b1, 5'd1, 5'd2, 32'd0, 1'b0, 3'd4, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("bp_hold", 1'b1, 5'd2, 5'd1, 32'd0, 1'b0, 3'd0, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0);
      expectField("bp_hold.ready", {31'd0, last_ready}, 32'd0);
      expectField("bp_hold.a", out_a, 32'd5);
    end
    applyStimulus("bp_rel1", 1'b1, 5'd2, 5'd1, 32'd0, 1'b0, 3'd0, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1);
    expectField("bp_rel1.a", out_a, 32'd3);
    applyStimulus("bp_rel2", 1'b1, 5'd1, 5'd2, 32'd0, 1'b0, 3'd1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1);
    expectField("bp_rel2.rd", {27'd0, out_rd}, 32'd7);

    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    modelReset();
    checkReset("mid_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post_reset", 1'b1, 5'd5, 5'd6, 32'd0, 1'b0, 3'd0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1);
    expectField("post_reset.ready", {31'd0, last_ready}, 32'd1);
    expectField("post_reset.a", out_a, 32'd0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand",
        ($urandom_range(0, 3) != 0),
        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom(),
        ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
        ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom(),
        ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
